dcache_wt_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the CPU MEM stage and Data_memory.
- CPU side keeps the Data_memory handshake (address, write_data, mem_read, mem_write, read_data) and adds a stall output.
- Memory side drives Data_memory directly. Data_memory is byte-addressed, word-per-index, combinational read, write on posedge.
- Read misses refill a 4-word line, one word per cycle; hit/miss counters are exposed for lab reporting.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_wt_ctrl_if.sv | 30 +++
 rtl/dcache_array.sv | 52 +++++
 rtl/dcache_wt_ctrl.sv | 153 +++++++++++++++
 tb/tb_dcache_wt_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types, constants and address-field width helpers for the
// write-through data cache.
package dcache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_BITS      = 2;
    localparam int OFFSET_BITS    = 4;

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Whatever is left of the 32-bit address above index and line offset.
    function automatic int tag_bits(input int sets);
        return 32 - OFFSET_BITS - $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_wt_ctrl_if.sv
// CPU MEM-stage side of the cache. It keeps the Data_memory handshake and adds
// a stall that freezes the pipeline.
interface dcache_wt_ctrl_if;

    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
    logic        stall;

    modport master (
        output address,
        output write_data,
        output mem_read,
        output mem_write,
        input  read_data,
        input  stall
    );

    modport slave (
        input  address,
        input  write_data,
        input  mem_read,
        input  mem_write,
        output read_data,
        output stall
    );

endinterface

// File: rtl/dcache_array.sv
// Valid, tag and data storage for a direct-mapped cache. It has one
// combinational word read port, one word write port and a tag/valid set port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int SETS = 64,
    localparam int IW   = index_bits(SETS),
    localparam int TW   = tag_bits(SETS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IW-1:0]        rd_index,
    input  logic [WORD_BITS-1:0] rd_word,
    output logic                 rd_valid,
    output logic [TW-1:0]        rd_tag,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_index,
    input  logic [WORD_BITS-1:0] wr_word,
    input  logic [31:0]          wr_data,
    input  logic                 set_en,
    input  logic [IW-1:0]        set_index,
    input  logic [TW-1:0]        set_tag
);

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags  [SETS];
    logic [31:0]     words [SETS*WORDS_PER_LINE];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[{rd_index, rd_word}];

    // Only valid bits are reset. Stale tags and data are harmless while their line is invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (set_en) begin
            valid[set_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            words[{wr_index, wr_word}] <= wr_data;
        end
        if (set_en) begin
            tags[set_index] <= set_tag;
        end
    end

endmodule

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses refill a 4-word line from Data_memory, one word per cycle.
module dcache_wt_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    dcache_wt_ctrl_if.slave         cpu,
    output logic [31:0]             dm_address,
    output logic [31:0]             dm_write_data,
    output logic                    dm_mem_read,
    output logic                    dm_mem_write,
    input  logic [31:0]             dm_read_data,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int IW = index_bits(SETS);
    localparam int TW = tag_bits(SETS);

    state_t                 state;
    state_t                 next_state;
    logic [1:0]             cnt;
    logic [31:4]            base_line;

    logic [IW-1:0]          req_index;
    logic [TW-1:0]          req_tag;
    logic [WORD_BITS-1:0]   req_word;
    logic [IW-1:0]          base_index;
    logic [TW-1:0]          base_tag;

    logic                   rd_valid;
    logic [TW-1:0]          rd_tag;
    logic [31:0]            rd_data;
    logic                   hit;
    logic                   is_store;
    logic                   is_load;

    logic                   wr_en;
    logic [IW-1:0]          wr_index;
    logic [WORD_BITS-1:0]   wr_word;
    logic [31:0]            wr_data;
    logic                   set_en;
    logic                   hit_evt;
    logic                   miss_evt;

    assign req_index  = cpu.address[3+IW:4];
    assign req_tag    = cpu.address[31:4+IW];
    assign req_word   = cpu.address[3:2];
    assign base_index = base_line[3+IW:4];
    assign base_tag   = base_line[31:4+IW];

    assign hit      = rd_valid && (rd_tag == req_tag);
    assign is_store = cpu.mem_write;
    assign is_load  = cpu.mem_read && !cpu.mem_write;

    dcache_array #(
        .SETS (SETS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (req_index),
        .rd_word   (req_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .set_en    (set_en),
        .set_index (base_index),
        .set_tag   (base_tag)
    );

    always_comb begin
        next_state    = state;
        cpu.stall     = 1'b0;
        cpu.read_data = '0;
        dm_mem_read   = 1'b0;
        dm_mem_write  = 1'b0;
        dm_address    = cpu.address;
        dm_write_data = cpu.write_data;
        wr_en         = 1'b0;
        wr_index      = req_index;
        wr_word       = req_word;
        wr_data       = cpu.write_data;
        set_en        = 1'b0;
        hit_evt       = 1'b0;
        miss_evt      = 1'b0;

        case (state)
            IDLE: begin
                // Stores always go through to memory. They update the line only when it is resident.
                if (is_store) begin
                    dm_mem_write = 1'b1;
                    wr_en        = hit;
                end else if (is_load) begin
                    if (hit) begin
                        cpu.read_data = rd_data;
                        hit_evt       = 1'b1;
                    end else begin
                        cpu.stall  = 1'b1;
                        miss_evt   = 1'b1;
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                cpu.stall   = 1'b1;
                dm_mem_read = 1'b1;
                dm_address  = {base_line, cnt, 2'b00};
                wr_en       = 1'b1;
                wr_index    = base_index;
                wr_word     = cnt;
                wr_data     = dm_read_data;
                if (cnt == 2'd3) begin
                    set_en     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (miss_evt) begin
                base_line <= cpu.address[31:4];
                cnt       <= 2'd0;
            end else if (state == REFILL) begin
                cnt <= cnt + 2'd1;
            end
            if (hit_evt) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_evt) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Self-checking bench for dcache_wt_ctrl. A line-level cache model predicts
// every cycle's outputs, and a few literal expectations pin that model.
module tb_dcache_wt_ctrl;

    localparam int SETS = 64;

    typedef struct {
        logic        stall;
        logic        chk_rd;
        logic [31:0] rd;
        logic        chk_dmrd;
        logic        dmrd;
        logic        dmwr;
        logic        chk_addr;
        logic [31:0] addr;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_read_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;

    exp_t expq[$];

    logic [31:0] ref_mem  [1024];
    logic        m_valid  [SETS];
    logic [31:0] m_tag    [SETS];
    logic [31:0] m_data   [SETS][4];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    always #5 clk = ~clk;

    dcache_wt_ctrl_if cpu ();

    dcache_wt_ctrl #(
        .SETS (SETS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu           (cpu.slave),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_mem_read   (dm_mem_read),
        .dm_mem_write  (dm_mem_write),
        .dm_read_data  (dm_read_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // Data_memory stand-in. The model itself applies the write-through stores.
    assign dm_read_data = ref_mem[dm_address[11:2]];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("stall", {31'd0, cpu.stall}, {31'd0, e.stall});
            if (e.chk_rd) checkOutput("read_data", cpu.read_data, e.rd);
            if (e.chk_dmrd) checkOutput("dm_mem_read", {31'd0, dm_mem_read}, {31'd0, e.dmrd});
            checkOutput("dm_mem_write", {31'd0, dm_mem_write}, {31'd0, e.dmwr});
            if (e.chk_addr) checkOutput("dm_address", dm_address, e.addr);
            if (e.chk_wdata) checkOutput("dm_write_data", dm_write_data, e.wdata);
            checkOutput("hit_count", hit_count, e.hits);
            checkOutput("miss_count", miss_count, e.misses);
        end
    end

    function automatic int idxOf(input logic [31:0] a);
        return int'((a / 16) % SETS);
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] a);
        return a / (16 * SETS);
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'((a / 4) % 4);
    endfunction

    function automatic logic modelHit(input logic [31:0] a);
        return m_valid[idxOf(a)] && (m_tag[idxOf(a)] == tagOf(a));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic pushExp(input logic stall, input logic chk_rd, input logic [31:0] rd,
                           input logic chk_dmrd, input logic dmrd, input logic dmwr,
                           input logic chk_addr, input logic [31:0] addr,
                           input logic chk_wdata, input logic [31:0] wdata);
        exp_t e;
        e.stall = stall; e.chk_rd = chk_rd; e.rd = rd;
        e.chk_dmrd = chk_dmrd; e.dmrd = dmrd; e.dmwr = dmwr;
        e.chk_addr = chk_addr; e.addr = addr;
        e.chk_wdata = chk_wdata; e.wdata = wdata;
        e.hits = m_hits; e.misses = m_misses;
        expq.push_back(e);
    endtask

    // kind: 0 idle, 1 load, 2 store, 3 read+write together (behaves as a store).
    task automatic applyStimulus(input int kind, input logic [31:0] addr,
                                 input logic [31:0] data, input logic abort_refill);
        logic [31:0] base;
        @(posedge clk);
        #1;
        cpu.address    = addr;
        cpu.write_data = data;
        cpu.mem_read   = (kind == 1 || kind == 3);
        cpu.mem_write  = (kind == 2 || kind == 3);
        if (kind == 0) begin
            pushExp(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        end else if (kind >= 2) begin
            pushExp(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, addr, 1'b1, data);
            ref_mem[addr[11:2]] = data;
            if (modelHit(addr)) m_data[idxOf(addr)][wordOf(addr)] = data;
        end else if (modelHit(addr)) begin
            pushExp(1'b0, 1'b1, m_data[idxOf(addr)][wordOf(addr)], 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            m_hits++;
        end else begin
            pushExp(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            m_misses++;
            base = addr & ~32'hF;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                if (abort_refill && k == 2) begin
                    rst          = 1'b1;
                    cpu.mem_read = 1'b0;
                end
                pushExp(1'b1, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, base + 32'(4 * k), 1'b0, 32'd0);
                if (abort_refill && k == 2) begin
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    modelReset();
                    pushExp(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
                    return;
                end
            end
            m_valid[idxOf(addr)] = 1'b1;
            m_tag[idxOf(addr)]   = tagOf(addr);
            for (int w = 0; w < 4; w++) m_data[idxOf(addr)][w] = ref_mem[base[11:2] + 10'(w)];
            @(posedge clk);
            #1;
            pushExp(1'b0, 1'b1, m_data[idxOf(addr)][wordOf(addr)], 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            m_hits++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        ref_mem[32'h3E0 >> 2] = 32'd1;
        ref_mem[32'h3E4 >> 2] = 32'd2;
        ref_mem[32'h3E8 >> 2] = 32'd3;
        ref_mem[32'h3EC >> 2] = 32'd4;
        ref_mem[32'h7E0 >> 2] = 32'h100;
        ref_mem[32'h7E4 >> 2] = 32'h101;
        ref_mem[32'h7E8 >> 2] = 32'h102;
        ref_mem[32'h7EC >> 2] = 32'h103;
        rst            = 1'b1;
        cpu.address    = 32'd0;
        cpu.write_data = 32'd0;
        cpu.mem_read   = 1'b0;
        cpu.mem_write  = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pushExp(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // The first load misses. Its data must be 3 after five stall cycles.
        applyStimulus(1, 32'h3E8, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("pin_first_load", cpu.read_data, 32'd3);
        checkOutput("pin_first_miss_count", miss_count, 32'd1);

        applyStimulus(1, 32'h3E0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("pin_hit_word0", cpu.read_data, 32'd1);
        applyStimulus(1, 32'h3E4, 32'd0, 1'b0);
        applyStimulus(1, 32'h3EC, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("pin_hit_word3", cpu.read_data, 32'd4);

        applyStimulus(2, 32'h3E8, 32'hDEADBEEF, 1'b0);
        applyStimulus(1, 32'h3E8, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("pin_store_hit_load", cpu.read_data, 32'hDEADBEEF);

        applyStimulus(2, 32'h800, 32'd7, 1'b0);
        applyStimulus(0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1, 32'h800, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("pin_store_miss_load", cpu.read_data, 32'd7);

        applyStimulus(3, 32'h3E4, 32'h55, 1'b0);
        applyStimulus(1, 32'h3E4, 32'd0, 1'b0);

        // Lines at 0x3E8 and 0x7E8 share an index, so each of these loads evicts the other line.
        applyStimulus(1, 32'h7E8, 32'd0, 1'b0);
        applyStimulus(1, 32'h3E8, 32'd0, 1'b0);
        applyStimulus(1, 32'h7E8, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("pin_conflict_load", cpu.read_data, 32'h102);
        applyStimulus(1, 32'h3E8, 32'd0, 1'b0);
        applyStimulus(0, 32'd0, 32'd0, 1'b0);

        applyStimulus(1, 32'h7E0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("pin_abort_hits", hit_count, 32'd0);
        checkOutput("pin_abort_misses", miss_count, 32'd0);
        applyStimulus(1, 32'h7E0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("pin_reload_data", cpu.read_data, 32'h100);
        checkOutput("pin_reload_misses", miss_count, 32'd1);

        applyStimulus(0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
